// File: rtl/fe_pkg.sv
// fe_pkg: field width, the Curve25519 prime and the state type shared by the field-arithmetic controllers
package fe_pkg;
  localparam int W = 255;
  localparam logic [W-1:0] P = {W{1'b1}} - W'(18);
  typedef enum logic [1:0] {IDLE, REDUCE, ITER, DONE} fe_state_e;
endpackage

// File: rtl/fe_half_mod.sv
// fe_half_mod: combinational x/2 mod P for x in [0, P-1]
module fe_half_mod
  import fe_pkg::*;
(
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  logic [W:0] sum;
  // odd x: adding P makes the sum even so the shift is exact
  assign sum = {1'b0, x_i} + ({(W+1){x_i[0]}} & {1'b0, P});
  assign y_o = sum[W:1];
endmodule

// File: rtl/fe_inverse_seq.sv
// fe_inverse_seq: a^-1 mod P by binary extended Euclid, one step per cycle
module fe_inverse_seq
  import fe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};
  fe_state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, x1_q, x1_d, x2_q, x2_d, res_q, res_d;
  logic [W-1:0] a_red, x1_half, x2_half, x1_sub, x2_sub;
  logic [W:0] u_q, u_d, v_q, v_d;
  logic err_q, err_d, busy_q, done_q;

  fe_half_mod u_half1 (.x_i(x1_q), .y_o(x1_half));
  fe_half_mod u_half2 (.x_i(x2_q), .y_o(x2_half));

  // a < 2^W < 2P, so one conditional subtraction fully reduces it
  assign a_red  = (a_q >= P) ? a_q - P : a_q;
  assign x1_sub = W'({1'b0, x1_q} + ((x1_q >= x2_q) ? {(W+1){1'b0}} : {1'b0, P}) - {1'b0, x2_q});
  assign x2_sub = W'({1'b0, x2_q} + ((x2_q >= x1_q) ? {(W+1){1'b0}} : {1'b0, P}) - {1'b0, x1_q});

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      busy_q  <= (state_d == REDUCE) || (state_d == ITER);
      done_q  <= state_d == DONE;
    end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? REDUCE : IDLE;
      REDUCE:  state_d = (a_red == '0) ? DONE : ITER;
      ITER:    state_d = (u_q == ONE || v_q == ONE) ? DONE : ITER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    u_d   = u_q;
    v_d   = v_q;
    x1_d  = x1_q;
    x2_d  = x2_q;
    res_d = res_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: a_d = start ? a : a_q;
      REDUCE: begin
        err_d = a_red == '0;
        res_d = '0;
        if (a_red != '0) begin
          u_d  = {1'b0, a_red};
          v_d  = {1'b0, P};
          x1_d = {{(W-1){1'b0}}, 1'b1};
          x2_d = '0;
        end
      end
      ITER:
        if (u_q == ONE) res_d = x1_q;
        else if (v_q == ONE) res_d = x2_q;
        else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_sub;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_sub;
        end
      default: ;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign err    = err_q;
endmodule

// File: tb/tb_fe_inverse_seq.sv
// tb_fe_inverse_seq: directed and random checks of the modular inverter against a Fermat-based reference
module tb_fe_inverse_seq;
  localparam int W = 255;
  typedef logic [W-1:0] fe_t;
  localparam fe_t PM = 255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;
  localparam fe_t INV2 = 255'h3fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fff7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  fe_t a = '0;
  logic busy, done, err;
  fe_t result;
  int total = 0;
  int bad = 0;

  fe_inverse_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input fe_t got, input fe_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic fe_t mulmod(input fe_t x, input fe_t y);
    logic [511:0] m = {257'b0, PM};
    logic [511:0] t = ({257'b0, x} * {257'b0, y}) % m;
    return t[W-1:0];
  endfunction

  // inverse as x^(P-2) mod P; yields 0 for x == 0 mod P, matching the error result
  function automatic fe_t inv_ref(input fe_t x);
    logic [511:0] m = {257'b0, PM};
    logic [511:0] r = 512'd1;
    logic [511:0] b = {257'b0, x} % m;
    fe_t e = PM - fe_t'(2);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic fe_t rand_fe();
    logic [255:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic wait_done(input string tag);
    int lat = 0;
    while (done !== 1'b1 && lat < 1100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " done"}, fe_t'(done), fe_t'(1'b1));
  endtask

  task automatic check_res(input string tag, input fe_t op);
    fe_t red = op % PM;
    chk({tag, " err"}, fe_t'(err), fe_t'(red == '0));
    chk({tag, " res"}, result, inv_ref(op));
    if (red != '0) chk({tag, " prod"}, mulmod(result, red), fe_t'(1));
  endtask

  task automatic run_op(input fe_t op, input string tag);
    @(negedge clk);
    a = op;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, fe_t'(busy), fe_t'(1'b1));
    wait_done(tag);
    check_res(tag, op);
    @(posedge clk); #1;
    chk({tag, " hold"}, result, inv_ref(op));
    chk({tag, " pulse"}, fe_t'(done), fe_t'(1'b0));
  endtask

  initial begin
    fe_t cur, nxt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", fe_t'(busy), '0);
    chk("rst done", fe_t'(done), '0);
    chk("rst err", fe_t'(err), '0);
    chk("rst result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a = fe_t'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("one busy1", fe_t'({busy, done}), fe_t'(2'b10));
    @(posedge clk); #1;
    chk("one busy2", fe_t'({busy, done}), fe_t'(2'b10));
    @(posedge clk); #1;
    chk("one done", fe_t'({busy, done, err}), fe_t'(3'b010));
    chk("one res", result, fe_t'(1));
    @(posedge clk); #1;
    chk("one pulse", fe_t'(done), '0);
    chk("one hold", result, fe_t'(1));
    run_op(fe_t'(2), "two");
    chk("two const", result, INV2);
    run_op(PM - fe_t'(1), "pm1");
    chk("pm1 const", result, PM - fe_t'(1));
    run_op(PM + fe_t'(1), "pp1");
    chk("pp1 const", result, fe_t'(1));
    run_op(PM, "p");
    chk("p err", fe_t'(err), fe_t'(1'b1));
    run_op('0, "zero");
    chk("zero err", fe_t'(err), fe_t'(1'b1));
    run_op({W{1'b1}}, "max");
    for (int i = 0; i < 60; i++) run_op(rand_fe(), "rand");
    cur = rand_fe();
    a = cur;
    start = 1'b1;
    @(posedge clk); #1;
    chk("hold busy", fe_t'(busy), fe_t'(1'b1));
    for (int r = 0; r < 3; r++) begin
      wait_done("held");
      check_res("held", cur);
      nxt = rand_fe();
      a = nxt;
      @(posedge clk); #1;
      chk("held idle", fe_t'({busy, done}), '0);
      @(posedge clk); #1;
      chk("held accept", fe_t'(busy), fe_t'(1'b1));
      cur = nxt;
    end
    start = 1'b0;
    wait_done("held last");
    check_res("held last", cur);
    @(posedge clk); #1;
    @(negedge clk);
    a = rand_fe() | fe_t'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort busy", fe_t'(busy), '0);
    chk("abort done", fe_t'(done), '0);
    chk("abort err", fe_t'(err), '0);
    chk("abort result", result, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("abort quiet", fe_t'({busy, done}), '0);
    end
    run_op(fe_t'(2), "after");
    chk("after const", result, INV2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
